cve2_ibus_arbiter: RTL and testbench
====================================

# cve2_ibus_arbiter

The instruction-side bus arbiter shares the core's single OBI instruction port between two requesters. Requester 0 is the IF-stage prefetch fetch path. Requester 1 is a secondary fetcher, such as a debug program-buffer loader or a boot-copy engine. The block sits between those requesters and the instruction memory. It uses round-robin arbitration, holds the selected request stable until it is granted, and tracks outstanding transactions in order so each `rvalid` is routed back to the requester that issued it.

## Interface
- `MaxOutstanding`, default 2: depth of the in-order owner FIFO, i.e. the maximum number of granted transactions still awaiting `rvalid`. Legal range 1..4.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `m_req_i` in 2: per-requester request; bit 0 is fetch, bit 1 is secondary.
- `m_addr_i` in 2x32: per-requester word address.
- `m_gnt_o` out 2: per-requester grant.
- `m_rvalid_o` out 2: per-requester response valid.
- `m_rdata_o` out 32: response data, shared by both requesters and qualified by `m_rvalid_o`.
- `m_err_o` out 1: response bus error, shared and qualified by `m_rvalid_o`.
- `instr_req_o` out 1: request to memory.
- `instr_addr_o` out 32: address to memory.
- `instr_gnt_i` in 1: grant from memory.
- `instr_rvalid_i` in 1: response valid from memory.
- `instr_rdata_i` in 32: response data from memory.
- `instr_err_i` in 1: response error from memory.
- `outstanding_o` out clog2(MaxOutstanding+1): current FIFO occupancy.
- `unexpected_rsp_o` out 1: sticky flag; set when `instr_rvalid_i` arrives while the FIFO is empty.

## Operation
- State: `rr_q` is the priority pointer (0 = requester 0 first). `lock_q` and `lock_id_q` hold a pending ungranted selection. The owner FIFO holds one 1-bit requester ID per entry, with `wptr`, `rptr` and `count`.
- Selection:
  - If `lock_q` is set, select `lock_id_q`.
  - Otherwise, if only one requester asserts `m_req_i`, select it.
  - If both assert it, select `rr_q`.
- `instr_req_o` = selected requester's `m_req_i` AND NOT `fifo_full`.
- `instr_addr_o` = selected requester's `m_addr_i`. When no request is selected, it is the address of requester `rr_q`.
- `m_gnt_o[sel]` = `instr_req_o & instr_gnt_i`. The other requester's grant is 0.
- Lock:
  - `lock_q` is set when `instr_req_o & ~instr_gnt_i`, with `lock_id_q` = the selected requester.
  - `lock_q` is cleared on the grant.
  - This keeps the address and owner stable across wait states, as OBI requires.
- On a grant handshake:
  - Push the selected requester's ID into the FIFO.
  - Set `rr_q` to the other requester ID.
- Response:
  - If `instr_rvalid_i` is high and the FIFO is not empty: `m_rvalid_o[head]` = 1, pop the head entry.
  - `m_rdata_o` = `instr_rdata_i` and `m_err_o` = `instr_err_i`, passed through combinationally.
- Simultaneous push and pop in one cycle: `count` is unchanged, and both pointers advance modulo `MaxOutstanding`.
- Full FIFO (`count == MaxOutstanding`): `instr_req_o` is forced to 0. A pop in the same cycle does not re-enable the request until the next cycle, which avoids a combinational `rvalid`->`req` path.
- Unexpected response (`rvalid` while the FIFO is empty): no `m_rvalid_o` is asserted, the FIFO is unchanged, and `unexpected_rsp_o` is set until reset.
- Reset:
  - `rr_q` = 0, `lock_q` = 0, `lock_id_q` = 0, FIFO empty, `unexpected_rsp_o` = 0.
  - Consequently `instr_req_o` = 0, `m_gnt_o` = 0, `m_rvalid_o` = 0 and `outstanding_o` = 0.
  - `m_rdata_o` and `m_err_o` follow their inputs.
  - Any outstanding responses that arrive after reset are handled as unexpected responses.

## Timing
- Request path: combinational, zero cycles from `m_req_i` to `instr_req_o`, and from `instr_gnt_i` to `m_gnt_o`.
- Response path: combinational, zero cycles from `instr_rvalid_i` to `m_rvalid_o`, with no added latency.
- FIFO occupancy, `rr_q` and the lock state update on the rising edge of `clk_i` after the handshake.
- Throughput: one grant per cycle while the FIFO is not full. With `MaxOutstanding`=2 and a memory with 1-cycle `rvalid`, a single requester sustains one transaction per cycle.
- Requesters must hold `m_req_i` and `m_addr_i` stable until `m_gnt_o`. Dropping a request while `lock_q` is set is illegal; the bench must assert on it.

## Test plan
- **Single requester, back-to-back.**
  - Stimulus: requester 0 requests addresses 0x100, 0x104, 0x108 with `gnt` always high and `rvalid` one cycle later.
  - Required: 3 grants on consecutive cycles; `m_rvalid_o` = 2'b01 three times with data in order; `outstanding_o` never exceeds 1.
- **Round-robin.**
  - Stimulus: both requesters hold a request continuously after reset.
  - Required: grants alternate 0,1,0,1; `instr_addr_o` alternates between the two requesters' addresses; responses are routed in the same order.
- **Wait-state lock.**
  - Stimulus: requester 1 selected, `gnt` low for 3 cycles; requester 0 raises a request in cycle 2.
  - Required: `instr_addr_o` stays on requester 1's address until the grant; requester 0 is granted next.
- **FIFO full.**
  - Stimulus: `MaxOutstanding`=2, `gnt` high, `rvalid` held off.
  - Required: after 2 grants, `instr_req_o`=0 and `outstanding_o`=2. After one `rvalid`, `instr_req_o` returns the following cycle.
- **Unexpected response and reset.**
  - Stimulus: `rvalid` pulses with an empty FIFO; then assert `rst_i` with 2 transactions outstanding.
  - Required: `unexpected_rsp_o`=1 with no `m_rvalid_o`. After reset, `outstanding_o`=0 and `unexpected_rsp_o`=0.
- **Error propagation.**
  - Stimulus: requester 1 transaction returns with `instr_err_i`=1.
  - Required: `m_rvalid_o`=2'b10 and `m_err_o`=1 in the same cycle.

Source files
------------

// File: rtl/cve2_ibus_arbiter.sv
// cve2_ibus_arbiter
// Shares one OBI instruction port between two requesters (0 = IF prefetch,
// 1 = secondary fetcher). Round-robin selection, selection locked across
// memory wait states, and an in-order owner FIFO that steers each rvalid
// back to the requester that issued the transaction.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   m_req_i/m_addr_i      per-requester request and word address
//   m_gnt_o/m_rvalid_o    per-requester grant and response valid
//   m_rdata_o/m_err_o     shared response data/error (qualified by m_rvalid_o)
//   instr_*               OBI master port towards instruction memory
//   outstanding_o         owner FIFO occupancy
//   unexpected_rsp_o      sticky: rvalid seen with no transaction outstanding
module cve2_ibus_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [1:0]                           m_req_i,
  input  logic [1:0][31:0]                     m_addr_i,
  output logic [1:0]                           m_gnt_o,
  output logic [1:0]                           m_rvalid_o,
  output logic [31:0]                          m_rdata_o,
  output logic                                 m_err_o,
  output logic                                 instr_req_o,
  output logic [31:0]                          instr_addr_o,
  input  logic                                 instr_gnt_i,
  input  logic                                 instr_rvalid_i,
  input  logic [31:0]                          instr_rdata_i,
  input  logic                                 instr_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 unexpected_rsp_o
);

  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [PW-1:0] LastPtr = PW'(MaxOutstanding - 1);
  localparam logic [CW-1:0] FullCnt = CW'(MaxOutstanding);

  logic                      r_rr;       // requester preferred on a tie
  logic                      r_lock;     // request presented but not yet granted
  logic                      r_lock_id;
  logic                      r_unexp;
  logic [MaxOutstanding-1:0] r_fifo;     // owner ID per outstanding transaction
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;

  logic w_sel, w_full, w_empty, w_push, w_pop, w_head;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + PW'(1);
  endfunction

  // A locked selection wins; otherwise a lone requester, otherwise r_rr.
  // With no request r_rr is chosen too, which also defines instr_addr_o.
  always_comb begin
    w_sel = r_rr;
    if (r_lock)                 w_sel = r_lock_id;
    else if (m_req_i == 2'b01)  w_sel = 1'b0;
    else if (m_req_i == 2'b10)  w_sel = 1'b1;
  end

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);

  // Full is taken from registered state only, so a same-cycle pop cannot
  // re-open the request path (no rvalid->req combinational path).
  assign instr_req_o  = m_req_i[w_sel] & ~w_full;
  assign instr_addr_o = m_addr_i[w_sel];
  assign w_push       = instr_req_o & instr_gnt_i;

  assign w_head = r_fifo[r_rptr];
  assign w_pop  = instr_rvalid_i & ~w_empty;

  always_comb begin
    m_gnt_o        = '0;
    m_gnt_o[w_sel] = w_push;
  end

  always_comb begin
    m_rvalid_o         = '0;
    m_rvalid_o[w_head] = w_pop;
  end

  assign m_rdata_o        = instr_rdata_i;
  assign m_err_o          = instr_err_i;
  assign outstanding_o    = r_count;
  assign unexpected_rsp_o = r_unexp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr      <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_unexp   <= 1'b0;
      r_fifo    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= f_inc(r_wptr);
        r_rr           <= ~w_sel;
        r_lock         <= 1'b0;
      end else if (instr_req_o) begin
        // Hold owner and address stable across OBI wait states.
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end

      if (w_pop) r_rptr <= f_inc(r_rptr);

      if (instr_rvalid_i & w_empty) r_unexp <= 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cve2_ibus_arbiter.sv
// Bench for cve2_ibus_arbiter: directed scenarios followed by randomized
// protocol-legal traffic, every cycle checked against a queue-based model.
module tb_cve2_ibus_arbiter;
  localparam int MAXO = 2;
  localparam logic [31:0] DX = 32'h5A5A_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic [1:0]       gnt_o, rv_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             ireq;
  logic [31:0]      iaddr;
  logic             gnt_i, rvalid_i, err_i;
  logic [31:0]      rdata_i;
  logic [$clog2(MAXO+1)-1:0] outst;
  logic             unexp;

  cve2_ibus_arbiter #(.MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .m_req_i(req), .m_addr_i(addr),
    .m_gnt_o(gnt_o), .m_rvalid_o(rv_o), .m_rdata_o(rdata_o), .m_err_o(err_o),
    .instr_req_o(ireq), .instr_addr_o(iaddr), .instr_gnt_i(gnt_i),
    .instr_rvalid_i(rvalid_i), .instr_rdata_i(rdata_i), .instr_err_i(err_i),
    .outstanding_o(outst), .unexpected_rsp_o(unexp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner queue, tie-break preference, pending selection.
  bit m_q[$];
  bit m_rr, m_lk, m_lkid, m_unexp;
  logic [1:0] m_lastg;

  // Memory responder used by directed steps: rvalid one cycle after grant.
  bit auto_mem;
  bit pend_rv;
  logic [31:0] pend_d;

  // Snapshots of the last checked cycle and per-test logs.
  logic [31:0] obs_addr;
  logic [1:0]  obs_gnt, obs_rv;
  logic        obs_req, obs_err, obs_unexp;
  int          obs_out, obs_max;
  int gq[$], aq[$], rq[$], dq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clr_logs();
    gq.delete(); aq.delete(); rq.delete(); dq.delete(); obs_max = 0;
  endtask

  // Check one cycle at the falling edge, advance the model, move to the
  // next cycle's input-drive point (1 time unit after the rising edge).
  task automatic cycle();
    bit sel, ereq;
    logic [1:0] egnt, erv;
    #4;
    if (m_lk)                sel = m_lkid;
    else if (req == 2'b01)   sel = 1'b0;
    else if (req == 2'b10)   sel = 1'b1;
    else                     sel = m_rr;
    ereq = req[sel] && (m_q.size() < MAXO);
    egnt = 2'b00;
    if (ereq && gnt_i) egnt[sel] = 1'b1;
    erv = 2'b00;
    if (rvalid_i && m_q.size() > 0) erv[m_q[0]] = 1'b1;

    chk("instr_req", ireq, ereq);
    chk("instr_addr", iaddr, addr[sel]);
    chk("m_gnt", gnt_o, egnt);
    chk("m_rvalid", rv_o, erv);
    chk("m_rdata", rdata_o, rdata_i);
    chk("m_err", err_o, err_i);
    chk("outstanding", outst, m_q.size());
    chk("unexpected", unexp, m_unexp);
    if (m_lk && !rst) chk("hold_req_while_locked", req[m_lkid], 1);

    obs_addr = iaddr; obs_gnt = gnt_o; obs_rv = rv_o; obs_req = ireq;
    obs_err = err_o; obs_unexp = unexp; obs_out = int'(outst);
    if (obs_out > obs_max) obs_max = obs_out;
    if (gnt_o != 2'b00) begin gq.push_back(gnt_o[1]); aq.push_back(iaddr); end
    if (rv_o != 2'b00)  begin rq.push_back(rv_o[1]);  dq.push_back(rdata_o); end

    m_lastg = egnt;
    pend_rv = !rst && ereq && gnt_i;
    pend_d  = addr[sel] ^ DX;
    if (rst) begin
      m_q.delete(); m_rr = 0; m_lk = 0; m_lkid = 0; m_unexp = 0;
    end else begin
      if (rvalid_i) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_unexp = 1;
      end
      if (ereq && gnt_i) begin m_q.push_back(sel); m_rr = !sel; m_lk = 0; end
      else if (ereq)     begin m_lk = 1; m_lkid = sel; end
    end
    @(posedge clk); #1;
    if (auto_mem) begin rvalid_i = pend_rv; rdata_i = pend_d; end
  endtask

  task automatic do_reset();
    rst = 1; req = 0; gnt_i = 0; rvalid_i = 0; err_i = 0;
    cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1; req = 0; addr = '0; gnt_i = 0; rvalid_i = 0; rdata_i = 0; err_i = 0;
    m_q.delete(); m_rr = 0; m_lk = 0; m_lkid = 0; m_unexp = 0; m_lastg = 0;
    auto_mem = 0; pend_rv = 0; pend_d = 0; obs_max = 0;
    #1;
    cycle(); cycle();
    rst = 0;
    cycle();
    chk("rst_instr_req", obs_req, 0);
    chk("rst_gnt", obs_gnt, 0);
    chk("rst_rvalid", obs_rv, 0);
    chk("rst_outstanding", obs_out, 0);
    chk("rst_unexpected", obs_unexp, 0);

    // Single requester, back-to-back
    auto_mem = 1; clr_logs();
    req = 2'b01; gnt_i = 1;
    addr[0] = 32'h100; cycle();
    addr[0] = 32'h104; cycle();
    addr[0] = 32'h108; cycle();
    req = 0; cycle(); cycle();
    chk("b2b_grants", gq.size(), 3);
    chk("b2b_rsp_n", rq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_gnt_id", qget(gq, i), 0);
      chk("b2b_rsp_id", qget(rq, i), 0);
      chk("b2b_rdata", qget(dq, i), (32'h100 + 4 * i) ^ DX);
    end
    chk("b2b_max_outstanding", obs_max, 1);

    // Round-robin with both requesters always requesting
    do_reset(); clr_logs();
    addr[0] = 32'h1000; addr[1] = 32'h2000; req = 2'b11; gnt_i = 1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (obs_gnt[0]) addr[0] += 4;
      if (obs_gnt[1]) addr[1] += 4;
    end
    req = 0; cycle(); cycle();
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt_id", qget(gq, i), i % 2);
      chk("rr_addr", qget(aq, i), ((i % 2) ? 32'h2000 : 32'h1000) + 4 * (i / 2));
      chk("rr_rsp_id", qget(rq, i), i % 2);
    end

    // Wait-state lock on requester 1
    do_reset(); clr_logs();
    addr[0] = 32'h1000; addr[1] = 32'h2000; req = 2'b10; gnt_i = 0;
    cycle(); chk("lock_addr_c0", obs_addr, 32'h2000);
    cycle(); chk("lock_addr_c1", obs_addr, 32'h2000);
    req = 2'b11;
    cycle(); chk("lock_addr_c2", obs_addr, 32'h2000);
    gnt_i = 1;
    cycle(); chk("lock_gnt", obs_gnt, 2'b10);
    req = 2'b01;
    cycle(); chk("lock_next_gnt", obs_gnt, 2'b01);
    chk("lock_next_addr", obs_addr, 32'h1000);
    req = 0; cycle(); cycle();

    // FIFO full with responses held off
    auto_mem = 0; do_reset();
    addr[0] = 32'h400; req = 2'b01; gnt_i = 1;
    cycle(); cycle();
    cycle();
    chk("full_req", obs_req, 0);
    chk("full_outstanding", obs_out, 2);
    rvalid_i = 1; rdata_i = 32'hCAFE;
    cycle();
    chk("full_pop_req", obs_req, 0);
    chk("full_pop_rv", obs_rv, 2'b01);
    rvalid_i = 0;
    cycle();
    chk("full_reopen_req", obs_req, 1);
    chk("full_reopen_gnt", obs_gnt, 2'b01);

    // Unexpected response, then reset with transactions outstanding
    do_reset();
    rvalid_i = 1; cycle();
    chk("unexp_no_rv", obs_rv, 0);
    rvalid_i = 0; cycle();
    chk("unexp_flag", obs_unexp, 1);
    req = 2'b01; gnt_i = 1; cycle(); cycle();
    req = 0; cycle();
    chk("pre_rst_outstanding", obs_out, 2);
    do_reset();
    cycle();
    chk("post_rst_outstanding", obs_out, 0);
    chk("post_rst_unexp", obs_unexp, 0);
    rvalid_i = 1; cycle();
    chk("stale_rsp_no_rv", obs_rv, 0);
    rvalid_i = 0; cycle();
    chk("stale_rsp_unexp", obs_unexp, 1);

    // Error response on requester 1
    auto_mem = 1; do_reset();
    addr[1] = 32'h3000; req = 2'b10; gnt_i = 1; cycle();
    req = 0; err_i = 1; cycle();
    chk("err_rv", obs_rv, 2'b10);
    chk("err_flag", obs_err, 1);
    err_i = 0; cycle();

    // Randomized legal traffic; requests are held until granted
    auto_mem = 0; do_reset();
    m_lastg = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(req[i] && !m_lastg[i])) begin
          req[i]  = 1'($urandom_range(0, 1));
          addr[i] = $urandom & 32'hFFFF_FFFC;
        end
      end
      gnt_i    = ($urandom_range(0, 3) != 0);
      rvalid_i = 1'($urandom_range(0, 1));
      rdata_i  = $urandom;
      err_i    = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 99) == 0);
      cycle();
      if (rst) m_lastg = 2'b11;
      rst = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
